// File: rtl/pipe_pkg.sv
// Shared widths and helpers for the pipeline stage register slice.
package pipe_pkg;

    localparam int CTRL_W_EXE = 3;
    localparam int DATA_W_EXE = 68;
    localparam int CTRL_W_MEM = 2;
    localparam int STATS_W    = 16;
    localparam int MAX_DEPTH  = 4;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/pipe_reg_slice.sv
// One register slice: valid bit, control bundle and payload, with load and flush-clear.
module pipe_reg_slice #(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 68
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld,
    input  logic              clr,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // Payload still loads on a flush so the datapath stays simple; only valid/ctrl are squashed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (ld) begin
            valid_q <= valid_i & ~clr;
            ctrl_q  <= clr ? '0 : ctrl_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_register.sv
// DEPTH-slice pipeline boundary register with freeze/flush and bubble gating of control.
// Optional stall/bubble statistics counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_register
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_EXE,
    parameter int DATA_W = DATA_W_EXE,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STATS_W-1:0] stall_cnt,
    output logic [STATS_W-1:0] bubble_cnt
`endif
);

    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_depth_check
        $error("pipe_stage_register: DEPTH must be within 1..4");
    end

    logic              ld;
    logic              valid_s [DEPTH];
    logic [CTRL_W-1:0] ctrl_s  [DEPTH];
    logic [DATA_W-1:0] data_s  [DEPTH];

    // Flush overrides freeze so a taken branch can squash a stalled stage.
    assign ld = ~freeze | flush;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slice
        logic              valid_in;
        logic [CTRL_W-1:0] ctrl_in;
        logic [DATA_W-1:0] data_in;

        if (i == 0) begin : g_head
            assign valid_in = in_valid;
            assign ctrl_in  = in_ctrl;
            assign data_in  = in_data;
        end else begin : g_body
            assign valid_in = valid_s[i-1];
            assign ctrl_in  = ctrl_s[i-1];
            assign data_in  = data_s[i-1];
        end

        pipe_reg_slice #(
            .CTRL_W(CTRL_W),
            .DATA_W(DATA_W)
        ) u_slice (
            .clk    (clk),
            .rst_n  (rst),
            .ld     (ld),
            .clr    (flush),
            .valid_i(valid_in),
            .ctrl_i (ctrl_in),
            .data_i (data_in),
            .valid_o(valid_s[i]),
            .ctrl_o (ctrl_s[i]),
            .data_o (data_s[i])
        );
    end

    assign out_valid = valid_s[DEPTH-1];
    assign out_ctrl  = valid_s[DEPTH-1] ? ctrl_s[DEPTH-1] : '0;
    assign out_data  = data_s[DEPTH-1];

    always_comb begin
        occupancy = 3'd0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + {2'b00, valid_s[i]};
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [STATS_W-1:0] stall_cnt_q;
    logic [STATS_W-1:0] bubble_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (freeze && !flush) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (ld && !valid_s[DEPTH-1]) begin
                bubble_cnt_q <= sat_inc(bubble_cnt_q);
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_register.sv
// Self-checking bench: DEPTH=1..4 instances share stimulus, each compared to a queue model.
module tb_pipe_stage_register;

    localparam int NDUT = 4;

    typedef struct {
        logic        v;
        logic [2:0]  c;
        logic [67:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_ctrl = 3'd0;
    logic [67:0] in_data = '0;

    logic        ov  [NDUT];
    logic [2:0]  oc  [NDUT];
    logic [67:0] od  [NDUT];
    logic [2:0]  occ [NDUT];
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] st_cnt [NDUT];
    logic [15:0] bb_cnt [NDUT];
    int          m_stall  [NDUT];
    int          m_bubble [NDUT];
`endif

    ent_t mq [NDUT][$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        pipe_stage_register #(
            .CTRL_W(3),
            .DATA_W(68),
            .DEPTH (g + 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .freeze    (freeze),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ctrl   (in_ctrl),
            .in_data   (in_data),
            .out_valid (ov[g]),
            .out_ctrl  (oc[g]),
            .out_data  (od[g]),
            .occupancy (occ[g])
`ifdef PIPE_STAGE_STATS_EN
            ,
            .stall_cnt (st_cnt[g]),
            .bubble_cnt(bb_cnt[g])
`endif
        );
    end

    // The stage is a fixed-length FIFO of DEPTH entries: head is the output.
    task automatic model_reset();
        ent_t z;
        z.v = 1'b0; z.c = 3'd0; z.d = '0;
        for (int d = 0; d < NDUT; d++) begin
            mq[d].delete();
            for (int k = 0; k <= d; k++) mq[d].push_back(z);
`ifdef PIPE_STAGE_STATS_EN
            m_stall[d] = 0;
            m_bubble[d] = 0;
`endif
        end
    endtask

    task automatic model_edge();
        ent_t e;
        for (int d = 0; d < NDUT; d++) begin
            if (flush || !freeze) begin
`ifdef PIPE_STAGE_STATS_EN
                if (!mq[d][0].v && m_bubble[d] < 65535) m_bubble[d]++;
`endif
                if (flush) begin
                    for (int k = 0; k < mq[d].size(); k++) begin
                        mq[d][k].v = 1'b0;
                        mq[d][k].c = 3'd0;
                    end
                end
                e.v = flush ? 1'b0 : in_valid;
                e.c = flush ? 3'd0 : in_ctrl;
                e.d = in_data;
                void'(mq[d].pop_front());
                mq[d].push_back(e);
            end else begin
`ifdef PIPE_STAGE_STATS_EN
                if (m_stall[d] < 65535) m_stall[d]++;
`endif
            end
        end
    endtask

    task automatic chk_all(input string tag);
        ent_t h;
        int   cnt;
        for (int d = 0; d < NDUT; d++) begin
            h = mq[d][0];
            cnt = 0;
            foreach (mq[d][k]) if (mq[d][k].v) cnt++;
            checks++;
            assert (ov[d] === h.v) else begin
                failures++;
                $error("FAIL %s valid D%0d got=%b exp=%b", tag, d + 1, ov[d], h.v);
            end
            checks++;
            assert (oc[d] === (h.v ? h.c : 3'd0)) else begin
                failures++;
                $error("FAIL %s ctrl D%0d got=%h exp=%h", tag, d + 1, oc[d], h.v ? h.c : 3'd0);
            end
            checks++;
            assert (od[d] === h.d) else begin
                failures++;
                $error("FAIL %s data D%0d got=%h exp=%h", tag, d + 1, od[d], h.d);
            end
            checks++;
            assert (occ[d] === 3'(cnt)) else begin
                failures++;
                $error("FAIL %s occ D%0d got=%0d exp=%0d", tag, d + 1, occ[d], cnt);
            end
`ifdef PIPE_STAGE_STATS_EN
            checks++;
            assert (st_cnt[d] === 16'(m_stall[d])) else begin
                failures++;
                $error("FAIL %s stall D%0d got=%0d exp=%0d", tag, d + 1, st_cnt[d], m_stall[d]);
            end
            checks++;
            assert (bb_cnt[d] === 16'(m_bubble[d])) else begin
                failures++;
                $error("FAIL %s bubble D%0d got=%0d exp=%0d", tag, d + 1, bb_cnt[d], m_bubble[d]);
            end
`endif
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (rst) model_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic drive(input logic fz, input logic fl, input logic v,
                         input logic [2:0] c, input logic [67:0] dat);
        freeze = fz; flush = fl; in_valid = v; in_ctrl = c; in_data = dat;
    endtask

    initial begin
        logic [95:0] r;
        logic [67:0] held_d;
        logic [2:0]  held_c;

        // Reset held with an active-looking input: nothing may appear.
        model_reset();
        drive(1'b0, 1'b0, 1'b1, 3'b111, 68'h5A5);
        #1;
        chk_all("reset");
        for (int i = 0; i < 3; i++) cycle("reset_hold");
        rst = 1'b1;

        // Latency: values 1..5 back to back, then bubbles to drain.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 3'(i), 68'(i));
            cycle("latency");
        end
        checks++;
        assert (occ[2] === 3'd3) else begin
            failures++;
            $error("FAIL latency_occ3 got=%0d exp=3", occ[2]);
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 68'h0);
        for (int i = 0; i < 4; i++) cycle("drain");

        // Freeze mid-stream: DEPTH=2 output must sit still for the whole stall.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 3'(i + 2), 68'(16 + i));
            cycle("pre_freeze");
        end
        held_d = od[1];
        held_c = oc[1];
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 3'b101, 68'hBAD);
            cycle("freeze");
            checks++;
            assert (od[1] === held_d && oc[1] === held_c) else begin
                failures++;
                $error("FAIL freeze_hold got=%h/%h exp=%h/%h", od[1], oc[1], held_d, held_c);
            end
        end
        drive(1'b0, 1'b0, 1'b1, 3'b011, 68'h33);
        for (int i = 0; i < 2; i++) cycle("post_freeze");

        // Flush beats freeze.
        drive(1'b1, 1'b1, 1'b1, 3'b111, 68'h77);
        cycle("flush_freeze");
        checks++;
        assert (occ[1] === 3'd0 && ov[1] === 1'b0 && oc[1] === 3'd0) else begin
            failures++;
            $error("FAIL flush_d2 got occ=%0d v=%b c=%h exp=0/0/0", occ[1], ov[1], oc[1]);
        end

        // Bubble carrying control bits: payload passes, control is gated.
        drive(1'b0, 1'b0, 1'b0, 3'b110, 68'hDEADBEEF);
        for (int i = 0; i < 4; i++) cycle("gating");
        checks++;
        assert (od[3] === 68'hDEADBEEF && oc[3] === 3'd0 && ov[3] === 1'b0) else begin
            failures++;
            $error("FAIL gating_d4 got d=%h c=%h v=%b exp=deadbeef/0/0", od[3], oc[3], ov[3]);
        end

        // Async reset asserted while freezing and flushing.
        drive(1'b1, 1'b0, 1'b1, 3'b111, 68'h1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 3'b111, 68'(i + 40));
            cycle("refill");
        end
        drive(1'b1, 1'b1, 1'b1, 3'b111, 68'h9);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        chk_all("async_reset");
        cycle("in_reset");
        rst = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            r = {$urandom, $urandom, $urandom};
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                  1'($urandom), 3'($urandom), r[67:0]);
            cycle("random");
        end

`ifdef PIPE_STAGE_STATS_EN
        // Stats: fresh start, 5 stalls, then drain 2 bubbles through DEPTH=1.
        rst = 1'b0;
        #1;
        model_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 3'd0, 68'h0);
        for (int i = 0; i < 5; i++) cycle("stats_stall");
        drive(1'b0, 1'b0, 1'b0, 3'd0, 68'h0);
        for (int i = 0; i < 2; i++) cycle("stats_bubble");
        checks++;
        assert (st_cnt[0] === 16'd5 && bb_cnt[0] === 16'd2) else begin
            failures++;
            $error("FAIL stats_small got=%0d/%0d exp=5/2", st_cnt[0], bb_cnt[0]);
        end
        drive(1'b1, 1'b0, 1'b0, 3'd0, 68'h0);
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        chk_all("stats_sat");
        checks++;
        assert (st_cnt[0] === 16'hFFFF) else begin
            failures++;
            $error("FAIL stats_sat got=%h exp=ffff", st_cnt[0]);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
